fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the instruction memory and decode path.
- Owns the fetch PC and issues word-aligned requests to a variable-latency instruction memory.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to decode under a valid/stall handshake.
- Handles branch redirects: flushes the queue and discards the in-flight response.

---
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_queue.sv | 173 +++++++++++++++++
 tb/tb_fetch_queue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch queue, the instruction memory and the decode stage.
// The master modport is the fetch queue itself; the slave modport is its environment.
interface fetch_queue_if #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               stall;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, stall
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, stall
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding memory
// request at a time and buffers {pc, instr} pairs for decode; redirects flush it.
module fetch_queue #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q [DEPTH];

    logic               ack_s;
    logic               push_s;
    logic               pop_s;
    logic [ADDR_W-1:0]  redirect_pc_s;
    logic [ADDR_W-1:0]  pc_plus4_s;

    assign ack_s         = imem_req_q && bus.imem_ack;
    assign redirect_pc_s = bus.redirect_pc & ~(ADDR_W'(3));
    assign pc_plus4_s    = fetch_pc_q + ADDR_W'(4);
    assign push_s        = ack_s && (state_q == ST_RUN) && !bus.redirect;
    assign pop_s         = if_valid_q && !bus.stall && !bus.redirect;

    // Next-state for fetch control, queue pointers and request outputs.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fetch_pc_d  = fetch_pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        case (state_q)
            ST_RUN: begin
                if (bus.redirect) begin
                    count_d    = '0;
                    rd_ptr_d   = '0;
                    wr_ptr_d   = '0;
                    fetch_pc_d = redirect_pc_s;
                    // An unanswered request cannot be withdrawn; its response is dropped later.
                    if (imem_req_q && !bus.imem_ack) begin
                        state_d = ST_DISCARD;
                    end else begin
                        imem_req_d  = 1'b1;
                        imem_addr_d = redirect_pc_s;
                    end
                end else begin
                    if (push_s) begin
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end else begin
                        wr_ptr_d = wr_ptr_q;
                    end
                    if (pop_s) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end else begin
                        rd_ptr_d = rd_ptr_q;
                    end
                    count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
                    if (push_s) begin
                        fetch_pc_d  = pc_plus4_s;
                        imem_req_d  = (count_d < DEPTH_C);
                        imem_addr_d = pc_plus4_s;
                    end else if (!imem_req_q) begin
                        imem_req_d  = (count_d < DEPTH_C);
                        imem_addr_d = fetch_pc_q;
                    end else begin
                        imem_req_d  = imem_req_q;
                        imem_addr_d = imem_addr_q;
                    end
                end
            end
            ST_DISCARD: begin
                if (bus.redirect) begin
                    fetch_pc_d = redirect_pc_s;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                if (ack_s) begin
                    state_d     = ST_RUN;
                    imem_req_d  = 1'b1;
                    imem_addr_d = fetch_pc_d;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Next head-of-queue view; a push into the slot the head moves to bypasses the array.
    always_comb begin
        if_valid_d = 1'b0;
        if_instr_d = '0;
        if_pc_d    = '0;
        if (count_d == '0) begin
            if_valid_d = 1'b0;
        end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
            if_valid_d = 1'b1;
            if_instr_d = bus.imem_rdata;
            if_pc_d    = imem_addr_q;
        end else begin
            if_valid_d = 1'b1;
            if_instr_d = instr_mem_q[rd_ptr_d];
            if_pc_d    = pc_mem_q[rd_ptr_d];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fetch_pc_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_instr_q  <= '0;
            if_pc_q     <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
        end
    end

    // Queue storage; entries are only read once counted as valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
            pc_mem_q[wr_ptr_q]    <= imem_addr_q;
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: zero-wait and 3-cycle memory models, stall, redirects, reset.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic zero_wait = 1'b1;
    int   wait_cnt;
    int   n_checks = 0;
    int   n_fail = 0;
    logic found;

    fetch_queue_if #(.ADDR_W(64), .INSTR_W(32)) fq ();

    fetch_queue #(
        .DEPTH   (4),
        .ADDR_W  (64),
        .INSTR_W (32),
        .RESET_PC(64'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (fq)
    );

    always #5 clk = ~clk;

    // Memory model: data equals address; ack either tied to req or on the 3rd cycle of a request.
    assign fq.imem_rdata = fq.imem_addr[31:0];
    assign fq.imem_ack   = zero_wait ? fq.imem_req : (fq.imem_req && (wait_cnt == 2));

    always @(posedge clk or negedge reset) begin
        if (!reset) wait_cnt <= 0;
        else if (!fq.imem_req || fq.imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic zw);
        reset = 1'b0;
        zero_wait = zw;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        fq.stall       = 1'b0;
        fq.redirect    = 1'b0;
        fq.redirect_pc = 64'h0;
        #2 reset = 1'b0;
        #1;
        check_eq("rst_if_valid", 64'(fq.if_valid), 64'd0);
        check_eq("rst_imem_req", 64'(fq.imem_req), 64'd0);
        check_eq("rst_imem_addr", fq.imem_addr, 64'h0);
        check_eq("rst_if_pc", fq.if_pc, 64'h0);
        check_eq("rst_if_instr", 64'(fq.if_instr), 64'h0);
        tick();
        reset = 1'b1;

        // Zero-wait streaming: one instruction per cycle after a 2-edge startup.
        tick();
        check_eq("t1_req", 64'(fq.imem_req), 64'd1);
        check_eq("t1_addr0", fq.imem_addr, 64'h0);
        check_eq("t1_valid_e1", 64'(fq.if_valid), 64'd0);
        tick();
        check_eq("t1_valid_e2", 64'(fq.if_valid), 64'd1);
        check_eq("t1_pc0", fq.if_pc, 64'h0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq("t1_valid", 64'(fq.if_valid), 64'd1);
            check_eq("t1_pc", fq.if_pc, 64'(4 * i));
            check_eq("t1_instr", 64'(fq.if_instr), 64'(4 * i));
        end

        // Stall fills the queue to DEPTH, request drops, release drains contiguously.
        fq.stall = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_eq("t2_pc_held", fq.if_pc, 64'd20);
        check_eq("t2_valid_held", 64'(fq.if_valid), 64'd1);
        check_eq("t2_req_full", 64'(fq.imem_req), 64'd0);
        fq.stall = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq("t2_drain_valid", 64'(fq.if_valid), 64'd1);
            check_eq("t2_drain_pc", fq.if_pc, 64'(20 + 4 * k));
        end

        // Redirect to 0x203 with ack and pop on the same edge, queue holding 3 entries.
        do_reset(1'b1);
        fq.stall = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_eq("t4_pre_addr", fq.imem_addr, 64'd12);
        check_eq("t4_pre_pc", fq.if_pc, 64'd0);
        fq.stall       = 1'b0;
        fq.redirect    = 1'b1;
        fq.redirect_pc = 64'h203;
        tick();
        fq.redirect = 1'b0;
        check_eq("t4_flush_valid", 64'(fq.if_valid), 64'd0);
        check_eq("t4_req", 64'(fq.imem_req), 64'd1);
        check_eq("t4_addr", fq.imem_addr, 64'h200);
        tick();
        check_eq("t4_new_valid", 64'(fq.if_valid), 64'd1);
        check_eq("t4_new_pc", fq.if_pc, 64'h200);
        check_eq("t4_new_instr", 64'(fq.if_instr), 64'h200);
        tick();
        check_eq("t4_next_pc", fq.if_pc, 64'h204);

        // 3-cycle memory: redirect while the request to 0x8 is outstanding.
        do_reset(1'b0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (fq.imem_addr == 64'h8) found = 1'b1;
        end
        check_eq("t3_wait_req8", 64'(found), 64'd1);
        tick();
        fq.redirect    = 1'b1;
        fq.redirect_pc = 64'h100;
        tick();
        fq.redirect = 1'b0;
        check_eq("t3_disc_valid", 64'(fq.if_valid), 64'd0);
        check_eq("t3_disc_req", 64'(fq.imem_req), 64'd1);
        check_eq("t3_disc_addr", fq.imem_addr, 64'h8);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (fq.imem_addr != 64'h8) found = 1'b1;
            else check_eq("t3_no_valid", 64'(fq.if_valid), 64'd0);
        end
        check_eq("t3_wait_addr", 64'(found), 64'd1);
        check_eq("t3_new_addr", fq.imem_addr, 64'h100);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (fq.if_valid) found = 1'b1;
        end
        check_eq("t3_wait_valid", 64'(found), 64'd1);
        check_eq("t3_first_pc", fq.if_pc, 64'h100);
        check_eq("t3_first_instr", 64'(fq.if_instr), 64'h100);

        // Two redirects on consecutive cycles; the last one wins after the ack.
        fq.redirect    = 1'b1;
        fq.redirect_pc = 64'h40;
        tick();
        check_eq("t5_disc_valid", 64'(fq.if_valid), 64'd0);
        check_eq("t5_disc_addr", fq.imem_addr, 64'h104);
        fq.redirect_pc = 64'h80;
        tick();
        fq.redirect = 1'b0;
        check_eq("t5_disc_valid2", 64'(fq.if_valid), 64'd0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (fq.imem_addr != 64'h104) found = 1'b1;
        end
        check_eq("t5_wait_addr", 64'(found), 64'd1);
        check_eq("t5_new_addr", fq.imem_addr, 64'h80);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (fq.if_valid) found = 1'b1;
        end
        check_eq("t5_wait_valid", 64'(found), 64'd1);
        check_eq("t5_first_pc", fq.if_pc, 64'h80);

        // Asynchronous reset mid-stream, then restart from RESET_PC.
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) tick();
        check_eq("t6_pre_valid", 64'(fq.if_valid), 64'd1);
        #3 reset = 1'b0;
        #1;
        check_eq("t6_async_valid", 64'(fq.if_valid), 64'd0);
        check_eq("t6_async_req", 64'(fq.imem_req), 64'd0);
        check_eq("t6_async_addr", fq.imem_addr, 64'h0);
        #2 reset = 1'b1;
        tick();
        check_eq("t6_restart_req", 64'(fq.imem_req), 64'd1);
        check_eq("t6_restart_addr", fq.imem_addr, 64'h0);
        tick();
        check_eq("t6_restart_valid", 64'(fq.if_valid), 64'd1);
        check_eq("t6_restart_pc", fq.if_pc, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
